// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the RAM-backed FIFO controller.
//   DW      : default data width (bits)
//   AW      : default address width; depth = 2**AW
//   DEPTH   : default number of RAM entries
//   state_t : RAM mode code driven on the controller's state output
//             ST_INIT = RAM clear cycle, ST_RUN = normal operation
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    typedef enum logic [3:0] {
        ST_INIT = 4'b0001,
        ST_RUN  = 4'b0010
    } state_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
// Pointer/occupancy controller for a FIFO whose storage is an external
// single-clock RAM with a registered read port (q_a). The parent places the
// RAM beside this block and wires it up by port name.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset (highest priority)
//   flush     in   synchronous empty-and-clear request
//   push      in   producer write request
//   data_in   in   producer write data [DW]
//   pop       in   consumer read request
//   data_a    out  RAM write data (pass-through of data_in) [DW]
//   addr_wa   out  RAM write address = write pointer [AW]
//   addr_ra   out  RAM read address = read pointer [AW]
//   we_a      out  RAM write enable = push accepted
//   re_a      out  RAM read enable = pop accepted
//   state     out  RAM mode code (ST_INIT clears the RAM and q_a) [4]
//   rd_valid  out  q_a holds popped data this cycle
//   count     out  occupancy 0..2**AW [AW+1]
//   full      out  count == 2**AW
//   empty     out  count == 0
//   ready     out  controller in ST_RUN
//   ovf       out  sticky: push refused while running
//   udf       out  sticky: pop refused while running
// ---------------------------------------------------------------------------
module ram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DW = fifo_pkg::DW,
    parameter int AW = fifo_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] data_in,
    input  logic          pop,
    output logic [DW-1:0] data_a,
    output logic [AW-1:0] addr_wa,
    output logic [AW-1:0] addr_ra,
    output logic          we_a,
    output logic          re_a,
    output logic [3:0]    state,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ready,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW-1:0] L_PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   L_CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   L_CNT_FULL = {1'b1, {AW{1'b0}}};

    state_t        r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_rd_valid;
    logic          r_ovf;
    logic          r_udf;

    logic          w_run;
    logic          w_full;
    logic          w_empty;
    logic          w_pop_acc;
    logic          w_push_acc;
    logic          w_push_err;
    logic          w_pop_err;

    assign w_run   = (r_state == ST_RUN);
    assign w_full  = (r_count == L_CNT_FULL);
    assign w_empty = (r_count == '0);

    // Pop is resolved first: a full FIFO may still take a push when a pop
    // frees the slot in the same cycle. The RAM reads before it writes, so
    // the shared address returns the old entry.
    assign w_pop_acc  = w_run & pop & ~w_empty;
    assign w_push_acc = w_run & push & (~w_full | w_pop_acc);

    // Refused requests only count as errors while running; ST_INIT
    // silently ignores the producer and consumer.
    assign w_push_err = w_run & push & ~w_push_acc;
    assign w_pop_err  = w_run & pop  & ~w_pop_acc;

    // Single sequential process: FSM plus every control register.
    // Flush reuses the reset values so a flushed FIFO is indistinguishable
    // from a freshly reset one, including killing an in-flight rd_valid.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state    <= ST_INIT;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: r_state <= ST_RUN;   // RAM clear takes exactly one cycle
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_INIT;
            endcase

            // q_a is registered inside the RAM, so data follows re_a by one cycle
            r_rd_valid <= w_pop_acc;

            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end

            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_push_err) begin
                r_ovf <= 1'b1;
            end
            if (w_pop_err) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign data_a   = data_in;
    assign addr_wa  = r_wr_ptr;
    assign addr_ra  = r_rd_ptr;
    assign we_a     = w_push_acc;
    assign re_a     = w_pop_acc;
    assign state    = r_state;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign ready    = w_run;
    assign ovf      = r_ovf;
    assign udf      = r_udf;

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DW, default 10: data width in bits.
REQ-003 Parameter AW, default 3: address width; depth is 2^AW = 8 entries.
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous request to empty the FIFO and clear the RAM.
REQ-007 push  input  1  write request from the producer.
REQ-008 data_in  input  DW  write data from the producer.
REQ-009 pop  input  1  read request from the consumer.
REQ-010 data_a  output  DW  RAM write data; a combinational pass-through of data_in.
REQ-011 addr_wa  output  AW  RAM write address; the registered write pointer.
REQ-012 addr_ra  output  AW  RAM read address; the registered read pointer.
REQ-013 we_a  output  1  RAM write enable (combinational): push accepted.
REQ-014 re_a  output  1  RAM read enable (combinational): pop accepted.
REQ-015 state  output  4  RAM mode code: ST_INIT=4'b0001 (RAM clear), ST_RUN=4'b0010.
REQ-016 rd_valid  output  1  high in the cycle the RAM's registered q_a carries popped data.
REQ-017 count  output  AW+1  occupancy, range 0..8.
REQ-018 full, empty  output  1 each  count==8 and count==0 respectively.
REQ-019 ready  output  1  high when state==ST_RUN.
REQ-020 ovf, udf  output  1 each  sticky overflow and underflow error flags.

Function
REQ-021 FSM: rst or flush -> ST_INIT; ST_INIT always -> ST_RUN on the next edge; ST_RUN holds until rst or flush.
REQ-022 ST_INIT lasts exactly one cycle per entry; the RAM clears all entries and q_a in that cycle.
REQ-023 In ST_INIT, push and pop are ignored: we_a=0, re_a=0, and neither error flag is set.
REQ-024 push_acc = ST_RUN & push & (!full | pop_acc).
REQ-025 pop_acc = ST_RUN & pop & !empty.
REQ-026 On push_acc, wr_ptr increments modulo 8 (wrap 7->0).
REQ-027 On pop_acc, rd_ptr increments modulo 8 (wrap 7->0).
REQ-028 count: +1 on push_acc only; -1 on pop_acc only; unchanged when both or neither occur.
REQ-029 Full with simultaneous push and pop: both are accepted; addr_wa==addr_ra; the RAM returns the old entry (read-before-write); count stays 8.
REQ-030 Empty with simultaneous push and pop: push is accepted, pop is rejected, udf is set, count becomes 1.
REQ-031 rd_valid SHALL be pop_acc delayed by one cycle; read latency is 1 cycle.
REQ-032 ovf is set on push & !push_acc in ST_RUN; udf is set on pop & !pop_acc in ST_RUN; both hold until rst or flush.
REQ-033 A flush mid-operation discards pending contents; in-flight rd_valid is forced to 0 in the cycle after the flush.

Reset
REQ-034 In the cycle after rst is sampled: state=ST_INIT, wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, ovf=0, udf=0, ready=0.
REQ-035 flush SHALL produce the same register values as rst.
REQ-036 rst SHALL take priority over flush, push and pop.

Structure
REQ-037 Package fifo_pkg SHALL hold ST_INIT, ST_RUN, DW=10, AW=3 and DEPTH=8.
REQ-038 The block SHALL contain no sub-module; the parent instantiates the RAM beside it and connects it by port name.
REQ-039 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-040 rst for 2 cycles, then release -> state=0001 for 1 cycle, then state=0010, ready=1, empty=1, count=0.
REQ-041 Push 0x3A1, 0x055, 0x2FF, then pop 3 times -> q_a returns 0x3A1, 0x055, 0x2FF on the 3 cycles with rd_valid=1; count ends at 0.
REQ-042 Push 9 values -> full=1 after the 8th; the 9th sets ovf=1 with we_a=0; count=8.
REQ-043 When full, push 0x111 and pop together -> the oldest entry is read, 0x111 is written at the same address, and count stays 8; pointers wrap from 7 to 0 after 8 such cycles.
REQ-044 When empty, pop -> udf=1, re_a=0, rd_valid=0; push and pop together -> count=1, udf=1.
REQ-045 Assert flush at count=5 while a pop is pending -> next cycle: state=0001, count=0, rd_valid=0, ovf=udf=0; a later pop returns no stale data.
